// File: rtl/wedding_light.sv
// Self-running 16-lamp wedding-light sequencer: converge, drain, optional blink, then sweep.
// Define WEDDING_LIGHT_BLINK_EN to include the four-step BLINK phase (36-step period instead of 32).
module wedding_light #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // A STEP_CYCLES of 0 behaves like 1, so the tick fires when the prescaler sits at 0.
  localparam logic [15:0] StepLast = (STEP_CYCLES == 0) ? 16'd0 : 16'(STEP_CYCLES - 1);

`ifdef WEDDING_LIGHT_BLINK_EN
  localparam logic [5:0] IdxLast   = 6'd35;
  localparam logic [5:0] SweepBase = 6'd20;
`else
  localparam logic [5:0] IdxLast   = 6'd31;
  localparam logic [5:0] SweepBase = 6'd16;
`endif

  logic [15:0] pre_q, pre_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] q_q, q_d;
  logic        tick;

  function automatic logic [15:0] pattern(input logic [5:0] i);
    logic [15:0] v;
    v = 16'h0000;
    if (i < 6'd16) begin
      case (i[3:0])
        4'd0:    v = 16'h8001;
        4'd1:    v = 16'hC003;
        4'd2:    v = 16'hE007;
        4'd3:    v = 16'hF00F;
        4'd4:    v = 16'hF81F;
        4'd5:    v = 16'hFC3F;
        4'd6:    v = 16'hFE7F;
        4'd7:    v = 16'hFFFF;
        4'd8:    v = 16'hFE7F;
        4'd9:    v = 16'hFC3F;
        4'd10:   v = 16'hF81F;
        4'd11:   v = 16'hF00F;
        4'd12:   v = 16'hE007;
        4'd13:   v = 16'hC003;
        4'd14:   v = 16'h8001;
        default: v = 16'h0000;
      endcase
    end
`ifdef WEDDING_LIGHT_BLINK_EN
    else if (i < SweepBase) begin
      v = i[0] ? 16'h5555 : 16'hAAAA;
    end
`endif
    else begin
      v = 16'h0001 << (i - SweepBase);
    end
    return v;
  endfunction

  always_comb begin
    tick  = (pre_q == StepLast);
    pre_d = tick ? 16'd0 : pre_q + 16'd1;
    idx_d = idx_q;
    q_d   = q_q;
    if (tick) begin
      q_d   = pattern(idx_q);
      idx_d = (idx_q == IdxLast) ? 6'd0 : idx_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= 16'd0;
      idx_q <= 6'd0;
      q_q   <= 16'h0000;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_wedding_light.sv
// Self-checking bench for wedding_light: three prescaler settings (1, 4, and 0-as-1) driven
// from one reset, compared each cycle against a rule-based pattern model with random resets.
module tb_wedding_light;

  logic        clk;
  logic        rst;
  logic [15:0] q1, q4, q0;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

`ifdef WEDDING_LIGHT_BLINK_EN
  localparam int Period    = 36;
  localparam int SweepBase = 20;
`else
  localparam int Period    = 32;
  localparam int SweepBase = 16;
`endif

  wedding_light #(.STEP_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .q(q1));
  wedding_light #(.STEP_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .q(q4));
  wedding_light #(.STEP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .q(q0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp image for step s of the sequence, built from the lamp-count rules.
  function automatic logic [15:0] refPattern(input int s);
    logic [15:0] v;
    int n;
    v = 16'h0000;
    if (s < 16) begin
      n = (s < 8) ? s + 1 : 15 - s;
      for (int p = 0; p < 16; p++)
        if (p < n || p > 15 - n) v[p] = 1'b1;
    end else if (s < SweepBase) begin
      v = ((s - 16) % 2 == 0) ? 16'hAAAA : 16'h5555;
    end else begin
      v[s - SweepBase] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [15:0] expQ(input int e, input int stepCycles);
    if (e < stepCycles) return 16'h0000;
    return refPattern((e / stepCycles - 1) % Period);
  endfunction

  task automatic checkOutput(input string tag, input bit inReset);
    logic [15:0] e1, e4;
    e1 = inReset ? 16'h0000 : expQ(edges, 1);
    e4 = inReset ? 16'h0000 : expQ(edges, 4);
    checks++;
    assert (q1 === e1) else begin
      errors++;
      $error("[TB] FAIL %s step1 edge %0d observed %h expected %h", tag, edges, q1, e1);
    end
    checks++;
    assert (q4 === e4) else begin
      errors++;
      $error("[TB] FAIL %s step4 edge %0d observed %h expected %h", tag, edges, q4, e4);
    end
    checks++;
    assert (q0 === e1) else begin
      errors++;
      $error("[TB] FAIL %s step0 edge %0d observed %h expected %h", tag, edges, q0, e1);
    end
  endtask

  task automatic applyStimulus(input int nEdges, input string tag);
    for (int i = 0; i < nEdges; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      checkOutput(tag, 1'b0);
    end
  endtask

  initial begin
    int runLen;
    int holdLen;
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("reset_hold", 1'b1);
    end

    rst   = 1'b1;
    edges = 0;
    applyStimulus(2 * Period + 9, "full_period");

    for (int r = 0; r < 20; r++) begin
      runLen = $urandom_range(1, 80);
      applyStimulus(runLen, "random_run");
      @(posedge clk);
      edges++;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_reset", 1'b1);
      holdLen = $urandom_range(0, 3);
      for (int h = 0; h < holdLen; h++) begin
        @(negedge clk);
        checkOutput("reset_low", 1'b1);
      end
      @(negedge clk);
      rst   = 1'b1;
      edges = 0;
      applyStimulus(1, "first_after_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wedding_light.md
# wedding_light

Decorative 16-lamp light sequencer that drives a fixed, repeating wedding-light pattern onto a 16-bit lamp bus. The pattern runs converge, drain, blink, then sweep. It is a self-running leaf block with no control inputs besides clock and reset. Its output drives lamp drivers or LEDs directly, one bit per lamp; bit 15 is the leftmost lamp.

## Interface
- STEP_CYCLES, default 1: clock cycles per pattern step; legal range 1..65535; a value of 0 is treated as 1.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- q  output  16  lamp outputs, registered; 1 = lamp on.

## Operation
- Internal state: 16-bit prescaler `pre`, step index `idx`, and output register `q`.
- `idx` ranges 0..35 with the blink feature compiled in, or 0..31 without it.
- Pattern by `idx` (with blink):
  - CONVERGE, idx 0-7: q = 8001, C003, E007, F00F, F81F, FC3F, FE7F, FFFF (hex). Lamps fill from both edges toward the centre.
  - DRAIN, idx 8-15: q = FE7F, FC3F, F81F, F00F, E007, C003, 8001, 0000. Lamps empty from the centre outward.
  - BLINK, idx 16-19: q = AAAA, 5555, AAAA, 5555.
  - SWEEP, idx 20-35: a single lit lamp, q = 0001 << (idx-20), giving 0001 up to 8000.
- On each step tick, `q` loads pattern(idx). Then idx becomes 0 if idx is the last index, otherwise idx+1.
- Period is 36 steps with blink, 32 steps without. After the last SWEEP step the next tick reloads 8001.
- Step tick: asserted when pre == STEP_CYCLES-1. On a tick, pre clears to 0; otherwise pre increments.
- Reset (rst = 0): q = 0000, idx = 0, pre = 0, applied immediately and independent of clk.
  - This holds while rst is low, including mid-pattern.
  - No other output value is possible during reset.

## Timing
- Reset values: q = 0x0000; no other outputs.
- Edges are counted as rising clk edges after rst rises.
- The first tick occurs at edge STEP_CYCLES, when q becomes 8001.
- A new q value appears every STEP_CYCLES edges. q is stable between ticks and has no glitches because it is a pure register output.
- With STEP_CYCLES = 1, q changes on every edge.
- Wrap-around: the transition from the last index back to idx 0 takes no extra cycle.
- Reset deasserted coincident with a clock edge: that edge counts as edge 0, so no tick occurs on it.

## Configuration
- Macro: WEDDING_LIGHT_BLINK_EN.
- Defined: the BLINK phase is present, idx range is 0..35, and the period is 36 steps.
- Undefined: the BLINK phase is removed. SWEEP occupies idx 16-31 with q = 0001 << (idx-16), and the period is 32 steps. DRAIN is followed directly by 0001.

## Test plan
- Hold rst = 0 for 100 cycles with clk running: q = 0000 on every cycle.
- STEP_CYCLES = 1, macro defined, release rst:
  - Edges 1-8 give 8001, C003, E007, F00F, F81F, FC3F, FE7F, FFFF.
  - Edges 9-16 give FE7F down to 0000.
- Same setup, later edges:
  - Edges 17-20 give AAAA, 5555, AAAA, 5555.
  - Edges 21-36 give 0001, 0002, and so on up to 8000.
  - Edge 37 gives 8001, confirming the wrap.
- STEP_CYCLES = 4: q stays 0000 through edges 1-3, is 8001 at edges 4-7, and C003 at edge 8.
- Assert rst low asynchronously mid-SWEEP, between edges:
  - q goes to 0000 before the next edge.
  - After release, edge 1 gives 8001.
- Macro undefined, STEP_CYCLES = 1: edge 16 gives 0000, edge 17 gives 0001, edge 32 gives 8000, and edge 33 gives 8001.
